// File: rtl/distributor.sv
// rtl/distributor.sv - QSPI nibble assembler with strict round-robin dispatch to encrypters
module distributor #(
  parameter int NUM_ENCRYPTERS  = 4,
  parameter int ENCRYPTER_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [3:0]                         qspi_data,
  input  logic                               qspi_valid,
  output logic                               qspi_ready,
  output logic [ENCRYPTER_WIDTH-1:0]         encrypters_data,
  input  logic [NUM_ENCRYPTERS-1:0]          encrypters_ready,
  output logic [NUM_ENCRYPTERS-1:0]          encrypters_load,
  output logic [1:0]                         state_out,
  output logic [$clog2(ENCRYPTER_WIDTH/4)-1:0] nibble_index_out,
  output logic [$clog2(NUM_ENCRYPTERS)-1:0]  encrypter_index_out,
  output logic [15:0]                        packet_count_out
);

  localparam int NIBBLES = ENCRYPTER_WIDTH / 4;
  localparam int NIB_W   = $clog2(NIBBLES);
  localparam int ENC_W   = $clog2(NUM_ENCRYPTERS);

  typedef enum logic [1:0] {
    RECEIVING = 2'b01,
    DISPATCH  = 2'b10
  } state_t;

  state_t                     state;
  state_t                     state_next;
  logic [NIB_W-1:0]           nibble_index;
  logic [ENC_W-1:0]           encrypter_index;
  logic [ENCRYPTER_WIDTH-1:0] assembly;
  logic [15:0]                packet_count;
  logic                       accept;
  logic                       dispatch;
  logic                       last_nibble;

  // qspi_ready is registered from the next state so it is glitch-free and equals (state == RECEIVING)
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RECEIVING;
      qspi_ready <= 1'b1;
    end else begin
      state      <= state_next;
      qspi_ready <= (state_next == RECEIVING);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RECEIVING: if (accept && last_nibble) state_next = DISPATCH;
      DISPATCH:  if (dispatch) state_next = RECEIVING;
      default:   state_next = RECEIVING;
    endcase
  end

  always_comb begin
    accept      = qspi_ready && qspi_valid;
    dispatch    = (state == DISPATCH) && encrypters_ready[encrypter_index];
    last_nibble = (nibble_index == NIB_W'(NIBBLES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nibble_index    <= '0;
      encrypter_index <= '0;
      assembly        <= '0;
      packet_count    <= '0;
      encrypters_data <= '0;
      encrypters_load <= '0;
    end else begin
      encrypters_load <= '0;
      if (accept) begin
        assembly[{nibble_index, 2'b00} +: 4] <= qspi_data;
        nibble_index <= last_nibble ? '0 : nibble_index + 1'b1;
      end
      // Only the current round-robin target may take the packet; other ready bits are ignored
      if (dispatch) begin
        encrypters_data <= assembly;
        encrypters_load <= NUM_ENCRYPTERS'(1) << encrypter_index;
        encrypter_index <= (encrypter_index == ENC_W'(NUM_ENCRYPTERS - 1)) ?
                           '0 : encrypter_index + 1'b1;
        packet_count    <= packet_count + 16'd1;
      end
    end
  end

  assign state_out           = state;
  assign nibble_index_out    = nibble_index;
  assign encrypter_index_out = encrypter_index;
  assign packet_count_out    = packet_count;

endmodule

// File: tb/tb_distributor.sv
// tb/tb_distributor.sv - directed self-checking bench for distributor
module tb_distributor;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  qspi_data;
  logic        qspi_valid;
  logic        qspi_ready;
  logic [31:0] encrypters_data;
  logic [3:0]  encrypters_ready;
  logic [3:0]  encrypters_load;
  logic [1:0]  state_out;
  logic [2:0]  nibble_index_out;
  logic [1:0]  encrypter_index_out;
  logic [15:0] packet_count_out;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  logic       mon_en = 1'b0;
  logic [3:0] prev_load = 4'b0;

  distributor #(.NUM_ENCRYPTERS(4), .ENCRYPTER_WIDTH(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .qspi_data           (qspi_data),
    .qspi_valid          (qspi_valid),
    .qspi_ready          (qspi_ready),
    .encrypters_data     (encrypters_data),
    .encrypters_ready    (encrypters_ready),
    .encrypters_load     (encrypters_load),
    .state_out           (state_out),
    .nibble_index_out    (nibble_index_out),
    .encrypter_index_out (encrypter_index_out),
    .packet_count_out    (packet_count_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Whole-run invariants: load one-hot/zero and single-cycle, ready mirrors RECEIVING, legal state
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (!$onehot0(encrypters_load) || (encrypters_load != 4'b0 && prev_load != 4'b0) ||
          qspi_ready !== (state_out == 2'b01) || !(state_out inside {2'b01, 2'b10}))
        $display("FAIL invariant @%0d: load=%b prev_load=%b qspi_ready=%b state=%b",
                 cyc, encrypters_load, prev_load, qspi_ready, state_out);
      else
        passed++;
      prev_load = encrypters_load;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    qspi_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send_nibble(input logic [3:0] d);
    int n = 0;
    qspi_data  = d;
    qspi_valid = 1'b1;
    while (!qspi_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 100) $display("FAIL send_nibble_timeout: ready stayed %b, required 1", qspi_ready);
    else passed++;
    @(posedge clk); #1;
    qspi_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [31:0] v);
    for (int k = 0; k < 8; k++) send_nibble(v[4*k +: 4]);
  endtask

  task automatic wait_load(input int budget, output logic [3:0] ld);
    ld = 4'b0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (encrypters_load != 4'b0) begin
        ld = encrypters_load;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total++;
    if ({state_out, qspi_ready, encrypters_load, encrypters_data, nibble_index_out,
         encrypter_index_out, packet_count_out} !== {2'b01, 1'b1, 4'b0, 32'b0, 3'b0, 2'b0, 16'b0})
      $display("FAIL reset_state: state=%b ready=%b load=%b data=%h nib=%0d enc=%0d cnt=%0d, required 01 1 0000 0 0 0 0",
               state_out, qspi_ready, encrypters_load, encrypters_data, nibble_index_out,
               encrypter_index_out, packet_count_out);
    else passed++;
  endtask

  task automatic test_single_packet();
    logic [3:0] ld;
    int t0 = 0;
    do_reset();
    encrypters_ready = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      send_nibble(4'(k + 1));
      if (k == 0) t0 = cyc;
    end
    wait_load(20, ld);
    total++;
    if (ld !== 4'b0001) $display("FAIL single_load: got %b, required 0001", ld); else passed++;
    total++;
    if (encrypters_data !== 32'h87654321) $display("FAIL single_data: got %h, required 87654321", encrypters_data); else passed++;
    total++;
    if (cyc - t0 + 1 != 9) $display("FAIL single_latency: got %0d, required 9", cyc - t0 + 1); else passed++;
    total++;
    if (packet_count_out !== 16'd1) $display("FAIL single_count: got %0d, required 1", packet_count_out); else passed++;
    total++;
    if (qspi_ready !== 1'b1) $display("FAIL single_ready_after: got %b, required 1", qspi_ready); else passed++;
    @(posedge clk); #1;
    total++;
    if (encrypters_load !== 4'b0) $display("FAIL single_load_drop: got %b, required 0000", encrypters_load); else passed++;
  endtask

  task automatic test_round_robin();
    logic [31:0] vals [5] = '{32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D, 32'h55AA33CC, 32'h0F0F1234};
    logic [3:0]  exp_ld [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0]  ld;
    int prev = 0;
    do_reset();
    encrypters_ready = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      send_packet(vals[p]);
      wait_load(20, ld);
      total++;
      if (ld !== exp_ld[p] || encrypters_data !== vals[p])
        $display("FAIL rr_packet%0d: load=%b data=%h, required %b %h", p, ld, encrypters_data, exp_ld[p], vals[p]);
      else passed++;
      if (p > 0) begin
        total++;
        if (cyc - prev != 9) $display("FAIL rr_period%0d: got %0d, required 9", p, cyc - prev); else passed++;
      end
      prev = cyc;
    end
    total++;
    if (packet_count_out !== 16'd5) $display("FAIL rr_count: got %0d, required 5", packet_count_out); else passed++;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    do_reset();
    encrypters_ready = 4'b1110;
    send_packet(32'hDEADBEEF);
    qspi_valid = 1'b1;
    qspi_data  = 4'hF;
    repeat (20) begin
      @(posedge clk); #1;
      if (encrypters_load != 4'b0 || qspi_ready != 1'b0) bad++;
    end
    total++;
    if (bad != 0 || state_out !== 2'b10)
      $display("FAIL bp_stall: bad_cycles=%0d state=%b, required 0 10", bad, state_out);
    else passed++;
    qspi_valid = 1'b0;
    encrypters_ready = 4'b1111;
    @(posedge clk); #1;
    total++;
    if (encrypters_load !== 4'b0001 || encrypters_data !== 32'hDEADBEEF || packet_count_out !== 16'd1)
      $display("FAIL bp_release: load=%b data=%h cnt=%0d, required 0001 deadbeef 1",
               encrypters_load, encrypters_data, packet_count_out);
    else passed++;
  endtask

  task automatic test_valid_gaps();
    logic [31:0] v = 32'hA5C31F06;
    logic [3:0]  ld;
    do_reset();
    encrypters_ready = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      qspi_valid = 1'b0;
      qspi_data  = 4'($urandom);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      send_nibble(v[4*k +: 4]);
      if (k == 2) begin
        total++;
        if (nibble_index_out !== 3'd3) $display("FAIL gap_index: got %0d, required 3", nibble_index_out); else passed++;
      end
    end
    wait_load(20, ld);
    total++;
    if (ld !== 4'b0001 || encrypters_data !== v)
      $display("FAIL gap_packet: load=%b data=%h, required 0001 %h", ld, encrypters_data, v);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] ld;
    do_reset();
    encrypters_ready = 4'b1111;
    for (int k = 0; k < 5; k++) send_nibble(4'hE);
    do_reset();
    total++;
    if (nibble_index_out !== 3'd0 || qspi_ready !== 1'b1 || encrypters_load !== 4'b0 || packet_count_out !== 16'd0)
      $display("FAIL mid_reset: nib=%0d ready=%b load=%b cnt=%0d, required 0 1 0000 0",
               nibble_index_out, qspi_ready, encrypters_load, packet_count_out);
    else passed++;
    send_packet(32'h13579BDF);
    wait_load(20, ld);
    total++;
    if (ld !== 4'b0001 || encrypters_data !== 32'h13579BDF)
      $display("FAIL mid_repacket: load=%b data=%h, required 0001 13579bdf", ld, encrypters_data);
    else passed++;
    encrypters_ready = 4'b0000;
    send_packet(32'h0BADF00D);
    do_reset();
    encrypters_ready = 4'b1111;
    wait_load(12, ld);
    total++;
    if (ld !== 4'b0 || packet_count_out !== 16'd0 || encrypters_data !== 32'b0 || state_out !== 2'b01)
      $display("FAIL dispatch_reset: load=%b cnt=%0d data=%h state=%b, required 0000 0 0 01",
               ld, packet_count_out, encrypters_data, state_out);
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    qspi_valid = 1'b0;
    qspi_data = 4'h0;
    encrypters_ready = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_valid_gaps();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
